pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle instruction sequencer for the NPC core: owns the PC register, drives instruction fetch over a valid/ready memory port, and holds each fetched instruction for one execute cycle. It forms the next PC from the branch-condition selects (PCAsrc/PCBsrc) produced for the current instruction. It stops on an ebreak request or a misaligned target and counts retired instructions. It sits between the instruction memory and the decode/execute datapath and gates architectural state updates through `exec_valid`.

## Interface
- `XLEN`, 32: data/address width.
- `RESET_PC`, 32'h8000_0000: PC value loaded by reset.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ifetch_req_valid`  out  1  fetch request valid.
- `ifetch_req_ready`  in  1  memory accepts request.
- `ifetch_addr`  out  XLEN  fetch address (= `pc`).
- `ifetch_resp_valid`  in  1  fetched word valid.
- `ifetch_rdata`  in  32  fetched instruction word.
- `inst`  out  32  latched instruction to decode.
- `pc`  out  XLEN  PC of the instruction in flight.
- `exec_valid`  out  1  one-cycle execute strobe; datapath commits regfile/memory writes only while high.
- `PCAsrc`  in  1  adder A select: 0 → constant 4, 1 → `imm`.
- `PCBsrc`  in  1  adder B select: 0 → `pc`, 1 → `rs1`.
- `imm`  in  XLEN  immediate from decode.
- `rs1`  in  XLEN  rs1 read value.
- `halt_req`  in  1  current instruction is ebreak.
- `halted`  out  1  sequencer stopped.
- `error`  out  1  stop was caused by a misaligned target.
- `instret`  out  64  retired-instruction counter.

## Operation
- States: BOOT, FETCH, WAIT, EXEC, HALT. The reset state is BOOT.
- BOOT: all request/strobe outputs are 0. Moves to FETCH next cycle unconditionally.
- FETCH: `ifetch_req_valid`=1 and `ifetch_addr`=`pc`, both held stable until `ifetch_req_ready`. On valid&ready, move to WAIT.
- WAIT: sample `ifetch_resp_valid` only in this state. On response, `inst` <= `ifetch_rdata` and move to EXEC. Responses arriving in any other state are ignored.
- EXEC: `exec_valid`=1 for exactly this cycle. `instret` increments by 1, wrapping modulo 2^64.
- Next-PC computation: `target` = (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc), XLEN-bit wraparound add. When PCBsrc=1 (jalr), bit 0 of `target` is forced to 0.
- EXEC priority, highest first:
  1. `halt_req`=1 → HALT. `pc` unchanged, `error` stays 0.
  2. `target[1:0]` != 0 → HALT with `error`=1. `pc` unchanged, so it still points at the faulting instruction.
  3. Otherwise `pc` <= `target` and move to FETCH.
- HALT: terminal state, left only by `rst`. `halted`=1; `ifetch_req_valid` and `exec_valid` are 0.
- `inst` holds its value until the next WAIT capture.
- Reset values: `pc`=RESET_PC, `inst`=0, `instret`=0, `halted`=0, `error`=0, `ifetch_req_valid`=0, `exec_valid`=0.
- Reset asserted mid-transaction (FETCH/WAIT/EXEC) immediately returns the block to BOOT with the reset values above. The memory is reset by the same `rst`, so no stale response arrives after reset.

## Timing
- Minimum 3 cycles per instruction: FETCH (ready same cycle) → WAIT (response next cycle) → EXEC.
- The earliest response is the cycle after request acceptance. A response coinciding with the acceptance edge is not captured.
- The first `ifetch_req_valid` appears in the 2nd cycle after `rst` deasserts.
- `halted`, `error`, `pc`, `instret` and `inst` are registered.
- `ifetch_req_valid` and `exec_valid` are decoded from state only. They have no combinational path from any input.
- `target` is combinational from `imm`, `rs1` and `pc`, sampled on the EXEC edge. Decode inputs need only be valid during EXEC.
- A back-to-back fetch follows EXEC with no bubble: EXEC → FETCH on the next cycle.

## Test plan
- Reset/boot: hold `rst` 3 cycles, release → BOOT one cycle, then `ifetch_req_valid`=1 with `ifetch_addr`=0x8000_0000; all other outputs at their reset values.
- Sequential fetch with stalls: `ifetch_req_ready` low 2 cycles, response delayed 3 cycles, PCAsrc=0/PCBsrc=0 → `ifetch_addr` stable during the stall, `inst` captured, next fetch at 0x8000_0004, `instret`=1.
- Taken branch and jalr: PCAsrc=1, PCBsrc=0, imm=-8 at pc 0x8000_0010 → next fetch 0x8000_0008. Then PCAsrc=1, PCBsrc=1, rs1=0x8000_0101, imm=0 → next fetch 0x8000_0100 (bit 0 cleared).
- Misaligned target: PCAsrc=1, PCBsrc=0, imm=6 at pc 0x8000_0000 → HALT with `halted`=1, `error`=1, `pc`=0x8000_0000; no further requests.
- ebreak: `halt_req`=1 in EXEC with a misaligned target also present → `halted`=1, `error`=0, `instret` incremented, `pc` unchanged.
- Reset mid-WAIT plus spurious response: assert `rst` during WAIT, then pulse `ifetch_resp_valid` during BOOT/FETCH → `inst` stays 0 and the sequencer fetches RESET_PC normally.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Instruction-fetch port between the PC sequencer and the
//               instruction memory. The request is a valid/ready handshake
//               carrying the fetch address. The response is a single-cycle
//               valid strobe carrying the fetched instruction word.
//   Signals   : ifetch_req_valid  - fetch request valid (sequencer -> memory)
//               ifetch_req_ready  - memory accepts request (memory -> sequencer)
//               ifetch_addr       - fetch address (sequencer -> memory)
//               ifetch_resp_valid - fetched word valid (memory -> sequencer)
//               ifetch_rdata      - fetched instruction word (memory -> sequencer)
//   Modports  : master = sequencer side, slave = memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            ifetch_req_valid;
    logic            ifetch_req_ready;
    logic [XLEN-1:0] ifetch_addr;
    logic            ifetch_resp_valid;
    logic [31:0]     ifetch_rdata;

    modport master (
        output ifetch_req_valid,
        output ifetch_addr,
        input  ifetch_req_ready,
        input  ifetch_resp_valid,
        input  ifetch_rdata
    );

    modport slave (
        input  ifetch_req_valid,
        input  ifetch_addr,
        output ifetch_req_ready,
        output ifetch_resp_valid,
        output ifetch_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle instruction sequencer. It owns the PC, fetches one
//               instruction at a time over the fetch port, holds the
//               instruction for a single execute cycle, and then forms the
//               next PC from the branch-condition selects. It stops on an
//               ebreak or on a misaligned target, and it counts retired
//               instructions.
//   Ports     : clk, rst   - clock, asynchronous active-high reset
//               mem        - instruction fetch port (pc_sequencer_if.master)
//               inst       - latched instruction to decode
//               pc         - PC of the instruction in flight
//               exec_valid - one-cycle execute strobe (commit enable)
//               PCAsrc     - adder A select: 0 -> 4, 1 -> imm
//               PCBsrc     - adder B select: 0 -> pc, 1 -> rs1
//               imm, rs1   - decode operands for the next-PC adder
//               halt_req   - current instruction is ebreak
//               halted     - sequencer stopped
//               error      - stop caused by a misaligned target
//               instret    - retired-instruction counter (64-bit, wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pc_sequencer_if.master         mem,
    output logic [31:0]            inst,
    output logic [XLEN-1:0]        pc,
    output logic                   exec_valid,
    input  wire logic              PCAsrc,
    input  wire logic              PCBsrc,
    input  wire logic [XLEN-1:0]   imm,
    input  wire logic [XLEN-1:0]   rs1,
    input  wire logic              halt_req,
    output logic                   halted,
    output logic                   error,
    output logic [63:0]            instret
);

    localparam logic [2:0] c_st_boot  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [63:0]     r_instret;
    logic            r_halted;
    logic            r_error;

    logic [XLEN-1:0] w_add_a;
    logic [XLEN-1:0] w_add_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_req_valid;
    logic            w_exec_valid;

    // Next-PC adder. For jalr (PCBsrc=1) bit 0 is cleared before the
    // alignment test, so an odd rs1+imm is legal as long as bit 1 is clear.
    assign w_add_a      = PCAsrc ? imm : c_pc_step;
    assign w_add_b      = PCBsrc ? rs1 : r_pc;
    assign w_sum        = w_add_a + w_add_b;
    assign w_target     = {w_sum[XLEN-1:1], w_sum[0] & ~PCBsrc};
    assign w_misaligned = |w_target[1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_boot:  w_next_state = c_st_fetch;
            c_st_fetch: if (mem.ifetch_req_ready)  w_next_state = c_st_wait;
            c_st_wait:  if (mem.ifetch_resp_valid) w_next_state = c_st_exec;
            c_st_exec:  w_next_state = (halt_req || w_misaligned) ? c_st_halt : c_st_fetch;
            c_st_halt:  w_next_state = c_st_halt;
            default:    w_next_state = c_st_boot;
        endcase
    end

    // Output decode: strobes depend on state only, never on inputs
    always_comb begin
        w_req_valid  = 1'b0;
        w_exec_valid = 1'b0;
        case (r_state)
            c_st_fetch: w_req_valid  = 1'b1;
            c_st_exec:  w_exec_valid = 1'b1;
            default: begin
                w_req_valid  = 1'b0;
                w_exec_valid = 1'b0;
            end
        endcase
    end

    // Architectural registers. A stop leaves the PC on the instruction that
    // caused it; the stopping instruction still counts as retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_instret <= 64'd0;
            r_halted  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (r_state == c_st_wait && mem.ifetch_resp_valid) begin
                r_inst <= mem.ifetch_rdata;
            end
            if (r_state == c_st_exec) begin
                r_instret <= r_instret + 64'd1;
                if (halt_req) begin
                    r_halted <= 1'b1;
                end else if (w_misaligned) begin
                    r_halted <= 1'b1;
                    r_error  <= 1'b1;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign mem.ifetch_req_valid = w_req_valid;
    assign mem.ifetch_addr      = r_pc;
    assign exec_valid           = w_exec_valid;
    assign inst                 = r_inst;
    assign pc                   = r_pc;
    assign instret              = r_instret;
    assign halted               = r_halted;
    assign error                = r_error;

endmodule
`default_nettype wire
